uart_rx: RTL
============

Name: uart_rx

Overview:
- UART receiver, counterpart to the team's fixed-frame UART transmitter on the iCE40 board.
- Accepts an 8N1 serial stream on the FTDI RX pin and recovers each byte with mid-bit sampling.
- The baud timing is a counter in the hwclk domain. No derived clock is used.
- Delivers each byte to downstream logic over a valid/ready handshake. Reports framing errors and overruns as one-cycle pulses.

Parameters:
- SOURCE_CLK, 12000000: hwclk frequency in Hz.
- TARGET_CLK, 9600: baud rate. Supported values are 4800, 9600 and 115200.
- DATA_BITS, 8: data bits per frame, sent LSB first.
- N, SOURCE_CLK/TARGET_CLK: hwclk cycles per bit (integer division). Derived; do not override.
- HALF, N/2: cycles from start-edge detection to the start-bit sample point. Derived.

Ports:
- hwclk, input, 1: sole clock, rising edge.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- ftdi_rx, input, 1: serial line. Idle-high and asynchronous to hwclk.
- rx_data, output, DATA_BITS: received byte. Stable while rx_valid is high.
- rx_valid, output, 1: byte available. Held high until consumed.
- rx_ready, input, 1: consumer accepts rx_data in any cycle where rx_valid and rx_ready are both high.
- rx_busy, output, 1: high in every state except IDLE.
- rx_frame_err, output, 1: one-cycle pulse when the stop bit is sampled low.
- rx_overrun, output, 1: one-cycle pulse when a good frame completes but the previous byte was not consumed.

Behaviour:
- Reset values, with rst_n low asynchronously forcing all of them:
  - rx_data = 0, rx_valid = 0, rx_frame_err = 0, rx_overrun = 0, rx_busy = 0.
  - State = IDLE, bit counter = 0, baud counter = 0.
  - Synchronizer flops = 1.
- Input path: 2-flop synchronizer on ftdi_rx produces rx_s. All decisions use rx_s.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - If rx_s == 0, go to START and clear the baud counter.
  - Otherwise stay.
- START:
  - The baud counter increments each cycle.
  - At counter == HALF-1, sample rx_s.
  - If the sample is 0, go to DATA, clear the counter and clear the bit count.
  - If the sample is 1, treat it as a glitch and return to IDLE. No flags are raised.
- DATA:
  - The counter runs 0..N-1.
  - At N-1, sample rx_s into the shift register: shift right, new bit enters the MSB. Then clear the counter and increment the bit count.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - At counter == N-1, sample rx_s.
  - If the sample is 1 (good frame), go to IDLE:
    - If rx_valid == 0, or rx_ready == 1 in this same cycle: load rx_data from the shift register and set rx_valid = 1 on the next edge.
    - Otherwise, pulse rx_overrun for one cycle. rx_data and rx_valid keep the old byte; the new byte is dropped.
  - If the sample is 0 (bad frame):
    - Pulse rx_frame_err for one cycle.
    - Do not load data; rx_valid is unchanged.
    - Go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a break condition from retriggering as a stream of start bits.
- Handshake:
  - rx_valid falls on the edge after any cycle with rx_valid && rx_ready, unless a new good frame loads in that same cycle; then rx_valid stays 1 with the new data.
  - rx_ready has no effect while rx_valid == 0.
- Latency, measured from the first hwclk edge where rx_s is low:
  - Start sample after HALF cycles.
  - Data bit k (k = 0..7) sampled at HALF + (k+1)·N.
  - Stop bit sampled at HALF + 9N.
  - rx_valid asserts on the following edge.
  - Add 2 cycles of synchronizer delay relative to the pin.
- Back-to-back frames: the next start edge is detected in IDLE immediately after STOP. Continuous 8N1 traffic at the nominal baud must be received without loss.
- Reset mid-frame: all state is discarded. After rst_n releases, the receiver must see rx_s high (IDLE) before the next start; a line held low at release is treated as a start edge.
- Counter widths are sized to hold N-1 for the default parameters at minimum. A 16-bit counter suffices.

Test Plan:
All scenarios use SOURCE_CLK=16, TARGET_CLK=1 (N=16, HALF=8) for speed. One full-parameter run sends 0x47 at 9600 baud.
1. Frame for 0x47 (line: 0,1,1,1,0,0,0,1,0,1, 16 cycles per bit), rx_ready = 1 → rx_valid high for exactly 1 cycle with rx_data = 0x47. rx_frame_err = 0 and rx_overrun = 0 throughout.
2. ftdi_rx low for 4 cycles, then high → FSM returns to IDLE, rx_busy drops, no rx_valid and no flags.
3. Frame 0xA5 with the stop bit driven 0, line held low a further 40 cycles, then high → single rx_frame_err pulse, rx_valid stays 0, no further starts until the line goes high. A subsequent 0x3C frame is received correctly.
4. Frames 0x11 then 0x22 back-to-back with rx_ready = 0 → rx_valid holds with 0x11; rx_overrun pulses once at the second stop sample. Raising rx_ready then drops rx_valid on the next edge.
5. Frames 0x55 and 0xAA back-to-back with rx_ready = 1 → two rx_valid pulses, data 0x55 then 0xAA. The second pulse is 10·N + 1 cycles after the first, ±1 cycle.
6. Assert rst_n low during data bit 4 of a frame, release with the line high, then send 0x81 → all outputs 0 while in reset, no spurious rx_valid, then rx_data = 0x81 received.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling from a baud counter,
// valid/ready byte delivery, one-cycle framing-error and overrun pulses.
module uart_rx #(
  parameter int SOURCE_CLK = 12000000,
  parameter int TARGET_CLK = 9600,
  parameter int DATA_BITS  = 8
) (
  input  logic                 hwclk,
  input  logic                 rst_n,
  input  logic                 ftdi_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_busy,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);
  localparam int N    = SOURCE_CLK / TARGET_CLK;
  localparam int HALF = N / 2;
  localparam int CW   = 16;
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] N_M1    = CW'(N - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_d;
  logic                   valid_d, ferr_d, ovr_d;

  assign rx_s    = sync_q[1];
  assign rx_busy = (state_q != IDLE);

  always_ff @(posedge hwclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], ftdi_rx};
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= ferr_d;
      rx_overrun   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = rx_data;
    // a handshake retires the held byte unless a new one loads below
    valid_d = rx_valid && !rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    case (state_q)
      IDLE: if (!rx_s) begin
        state_d = START;
        cnt_d   = '0;
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rx_s ? IDLE : DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      DATA: begin
        if (cnt_q == N_M1) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = '0;
          bit_d   = bit_q + BW'(1);
          if (bit_q == LAST) state_d = STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
      STOP: begin
        if (cnt_q == N_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = IDLE;
            if (!rx_valid || rx_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else ovr_d = 1'b1;
          end else begin
            // wait out a held-low line so a break is not seen as many starts
            ferr_d  = 1'b1;
            state_d = WAIT_HIGH;
          end
        end else cnt_d = cnt_q + CW'(1);
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
